// File: rtl/legup_mult_pkg.sv
// Shared constants and product-fitting helper for the streaming multiplier.
// Signed-mode encoding plus width extension/truncation of the full product.
package legup_mult_pkg;

    localparam logic REP_UNSIGNED = 1'b0;
    localparam logic REP_SIGNED   = 1'b1;

    localparam int MAXW = 256;

    // Widens a full-width product to MAXW bits, sign- or zero-filling above fw.
    function automatic logic [MAXW-1:0] fit_product(
        input logic [MAXW-1:0] full,
        input int              fw,
        input logic            rep
    );
        logic [MAXW-1:0] r;
        logic            ext;
        logic [7:0]      msb;
        msb = 8'(fw - 1);
        ext = (rep == REP_SIGNED) && full[msb];
        for (int i = 0; i < MAXW; i++) begin
            r[i] = (i < fw) ? full[i] : ext;
        end
        return r;
    endfunction

endpackage

// File: rtl/legup_mult_stage.sv
// One pipeline register stage: payload, signed bit, tag and valid bit.
// Loads when the upstream side advances; otherwise holds everything.
module legup_mult_stage
    import legup_mult_pkg::*;
#(
    parameter int DW   = 64,
    parameter int TAGW = 8
) (
    input  logic            clock,
    input  logic            aclr_n,
    input  logic            i_flush,
    input  logic            i_load,
    input  logic            i_valid,
    input  logic [DW-1:0]   i_data,
    input  logic            i_sgn,
    input  logic [TAGW-1:0] i_tag,
    output logic            o_valid,
    output logic [DW-1:0]   o_data,
    output logic            o_sgn,
    output logic [TAGW-1:0] o_tag
);

    logic            r_valid;
    logic [DW-1:0]   r_data;
    logic            r_sgn;
    logic [TAGW-1:0] r_tag;

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sgn   <= REP_UNSIGNED;
            r_tag   <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= i_valid;
            // Bubbles only clear the valid bit; payload keeps its last value
            if (i_valid) begin
                r_data <= i_data;
                r_sgn  <= i_sgn;
                r_tag  <= i_tag;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_sgn   = r_sgn;
    assign o_tag   = r_tag;

endmodule

// File: rtl/legup_mult_pipelined_stream.sv
// Pipelined signed/unsigned multiplier with valid/ready streaming and tags.
// Operand stages precede the multiplier, product stages follow it.
module legup_mult_pipelined_stream
    import legup_mult_pkg::*;
#(
    parameter int WIDTHA   = 32,
    parameter int WIDTHB   = 32,
    parameter int WIDTHP   = 64,
    parameter int PIPELINE = 3,
    parameter int TAGW     = 8
) (
    input  logic              clock,
    input  logic              aclr_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTHA-1:0] in_a,
    input  logic [WIDTHB-1:0] in_b,
    input  logic              in_signed,
    input  logic [TAGW-1:0]   in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTHP-1:0] out_p,
    output logic [TAGW-1:0]   out_tag
);

    localparam int NI = PIPELINE >> 1;
    localparam int FW = WIDTHA + WIDTHB;

    logic            w_v   [PIPELINE];
    logic            w_adv [PIPELINE];
    logic [FW-1:0]   w_d   [PIPELINE];
    logic            w_s   [PIPELINE];
    logic [TAGW-1:0] w_t   [PIPELINE];
    logic            w_in_ready;

    logic [WIDTHA-1:0] w_m_a;
    logic [WIDTHB-1:0] w_m_b;
    logic              w_m_s;
    logic [FW-1:0]     w_ax;
    logic [FW-1:0]     w_bx;
    logic [FW-1:0]     w_full;

    // Advance chain runs from the output back towards the input
    always_comb begin
        for (int k = 0; k < PIPELINE; k++) begin
            w_adv[k] = 1'b0;
        end
        w_adv[PIPELINE-1] = out_ready;
        for (int k = PIPELINE - 2; k >= 0; k--) begin
            w_adv[k] = !w_v[k+1] || w_adv[k+1];
        end
    end

    assign w_in_ready = !flush && (!w_v[0] || w_adv[0]);
    assign in_ready   = w_in_ready;

    if (NI == 0) begin : g_mul_in
        assign w_m_a = in_a;
        assign w_m_b = in_b;
        assign w_m_s = in_signed;
    end else begin : g_mul_reg
        assign w_m_a = w_d[NI-1][FW-1:WIDTHB];
        assign w_m_b = w_d[NI-1][WIDTHB-1:0];
        assign w_m_s = w_s[NI-1];
    end

    assign w_ax = (w_m_s == REP_SIGNED)
                ? {{WIDTHB{w_m_a[WIDTHA-1]}}, w_m_a}
                : {{WIDTHB{1'b0}}, w_m_a};
    assign w_bx = (w_m_s == REP_SIGNED)
                ? {{WIDTHA{w_m_b[WIDTHB-1]}}, w_m_b}
                : {{WIDTHA{1'b0}}, w_m_b};
    assign w_full = w_ax * w_bx;

    for (genvar k = 0; k < PIPELINE; k++) begin : g_stage
        logic            w_ld;
        logic            w_sv;
        logic            w_ss;
        logic [FW-1:0]   w_sd;
        logic [TAGW-1:0] w_st;

        if (k == 0) begin : g_src_in
            assign w_ld = w_in_ready;
            assign w_sv = in_valid;
            assign w_ss = in_signed;
            assign w_st = in_tag;
        end else begin : g_src_prev
            assign w_ld = w_adv[k-1];
            assign w_sv = w_v[k-1];
            assign w_ss = w_s[k-1];
            assign w_st = w_t[k-1];
        end

        if (k == NI) begin : g_dat_mul
            assign w_sd = w_full;
        end else if (k == 0) begin : g_dat_in
            assign w_sd = {in_a, in_b};
        end else begin : g_dat_prev
            assign w_sd = w_d[k-1];
        end

        legup_mult_stage #(
            .DW   (FW),
            .TAGW (TAGW)
        ) u_stage (
            .clock   (clock),
            .aclr_n  (aclr_n),
            .i_flush (flush),
            .i_load  (w_ld),
            .i_valid (w_sv),
            .i_data  (w_sd),
            .i_sgn   (w_ss),
            .i_tag   (w_st),
            .o_valid (w_v[k]),
            .o_data  (w_d[k]),
            .o_sgn   (w_s[k]),
            .o_tag   (w_t[k])
        );
    end

    assign out_valid = w_v[PIPELINE-1];
    assign out_tag   = w_t[PIPELINE-1];
    assign out_p     = WIDTHP'(fit_product(MAXW'(w_d[PIPELINE-1]), FW,
                                           w_s[PIPELINE-1]));

endmodule

// File: tb/tb_legup_mult_pipelined_stream.sv
// Self-checking bench: four configurations of the streaming multiplier
// checked against an exact-arithmetic reference model.
module tb_legup_mult_pipelined_stream;

    int n_tests = 0;
    int n_fail  = 0;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic aclr_n;
    logic flush;

    logic        m_iv, m_ir, m_is, m_ov, m_or;
    logic [31:0] m_a, m_b;
    logic [7:0]  m_it, m_ot;
    logic [63:0] m_p;

    logic        s_iv, s_ir, s_is, s_ov, s_or;
    logic [31:0] s_a, s_b;
    logic [7:0]  s_it, s_ot;
    logic [63:0] s_p;

    logic        h_iv, h_ir, h_is, h_ov, h_or;
    logic [15:0] h_a, h_b, h_p;
    logic [7:0]  h_it, h_ot;

    logic        x_iv, x_ir, x_is, x_ov, x_or;
    logic [15:0] x_a, x_b;
    logic [39:0] x_p;
    logic [7:0]  x_it, x_ot;

    legup_mult_pipelined_stream #(
        .WIDTHA(32), .WIDTHB(32), .WIDTHP(64), .PIPELINE(3), .TAGW(8)
    ) dut (
        .clock(clock), .aclr_n(aclr_n), .flush(flush),
        .in_valid(m_iv), .in_ready(m_ir), .in_a(m_a), .in_b(m_b),
        .in_signed(m_is), .in_tag(m_it), .out_valid(m_ov),
        .out_ready(m_or), .out_p(m_p), .out_tag(m_ot)
    );

    legup_mult_pipelined_stream #(
        .WIDTHA(32), .WIDTHB(32), .WIDTHP(64), .PIPELINE(1), .TAGW(8)
    ) dut_p1 (
        .clock(clock), .aclr_n(aclr_n), .flush(flush),
        .in_valid(s_iv), .in_ready(s_ir), .in_a(s_a), .in_b(s_b),
        .in_signed(s_is), .in_tag(s_it), .out_valid(s_ov),
        .out_ready(s_or), .out_p(s_p), .out_tag(s_ot)
    );

    legup_mult_pipelined_stream #(
        .WIDTHA(16), .WIDTHB(16), .WIDTHP(16), .PIPELINE(3), .TAGW(8)
    ) dut_w16 (
        .clock(clock), .aclr_n(aclr_n), .flush(flush),
        .in_valid(h_iv), .in_ready(h_ir), .in_a(h_a), .in_b(h_b),
        .in_signed(h_is), .in_tag(h_it), .out_valid(h_ov),
        .out_ready(h_or), .out_p(h_p), .out_tag(h_ot)
    );

    legup_mult_pipelined_stream #(
        .WIDTHA(16), .WIDTHB(16), .WIDTHP(40), .PIPELINE(3), .TAGW(8)
    ) dut_w40 (
        .clock(clock), .aclr_n(aclr_n), .flush(flush),
        .in_valid(x_iv), .in_ready(x_ir), .in_a(x_a), .in_b(x_b),
        .in_signed(x_is), .in_tag(x_it), .out_valid(x_ov),
        .out_ready(x_or), .out_p(x_p), .out_tag(x_ot)
    );

    // Exact mathematical product reduced modulo 2**wp
    function automatic logic [63:0] ref_mul(
        input logic [31:0] a, input logic [31:0] b, input bit s,
        input int wa, input int wb, input int wp
    );
        logic signed [127:0] x, y, p;
        logic [63:0] m;
        x = {96'd0, a};
        y = {96'd0, b};
        x = x << (128 - wa);
        y = y << (128 - wb);
        x = s ? (x >>> (128 - wa)) : (x >> (128 - wa));
        y = s ? (y >>> (128 - wb)) : (y >> (128 - wb));
        p = x * y;
        m = (wp >= 64) ? '1 : ((64'd1 << wp) - 64'd1);
        return p[63:0] & m;
    endfunction

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 7))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h0000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_m(input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic [7:0] t);
        m_iv = 1'b1;
        m_a  = a;
        m_b  = b;
        m_is = s;
        m_it = t;
    endtask

    task automatic test_reset();
        repeat (2) cyc();
        n_tests++;
        if (m_ov !== 1'b0 || m_p !== 64'd0 || m_ot !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_main: ov=%b p=%h tag=%h want 0/0/0",
                     m_ov, m_p, m_ot);
        end
        n_tests++;
        if (s_ov !== 1'b0 || s_p !== 64'd0 || s_ot !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_p1: ov=%b p=%h tag=%h want 0/0/0",
                     s_ov, s_p, s_ot);
        end
        n_tests++;
        if (h_p !== 16'd0 || x_p !== 40'd0 || h_ov !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_width: p16=%h p40=%h ov=%b want 0",
                     h_p, x_p, h_ov);
        end
        aclr_n = 1'b1;
        #1;
        n_tests++;
        if (m_ir !== 1'b1 || s_ir !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: main=%b p1=%b want 1",
                     m_ir, s_ir);
        end
    endtask

    task automatic test_stream();
        logic [63:0] e0, e1, e2;
        e0 = ref_mul(32'd3, 32'd5, 1'b0, 32, 32, 64);
        e1 = ref_mul(32'hFFFF_FFFF, 32'd2, 1'b0, 32, 32, 64);
        e2 = ref_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32, 32, 64);
        m_or = 1'b1;
        drive_m(32'd3, 32'd5, 1'b0, 8'h11);
        cyc();
        drive_m(32'hFFFF_FFFF, 32'd2, 1'b0, 8'h22);
        cyc();
        drive_m(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 8'h33);
        cyc();
        n_tests++;
        if (m_ov !== 1'b1 || m_p !== e0 || m_ot !== 8'h11) begin
            n_fail++;
            $display("FAIL stream_0: ov=%b p=%h tag=%h want 1 %h 11",
                     m_ov, m_p, m_ot, e0);
        end
        m_iv = 1'b0;
        cyc();
        n_tests++;
        if (m_ov !== 1'b1 || m_p !== e1 || m_ot !== 8'h22) begin
            n_fail++;
            $display("FAIL stream_1: ov=%b p=%h tag=%h want 1 %h 22",
                     m_ov, m_p, m_ot, e1);
        end
        cyc();
        n_tests++;
        if (m_ov !== 1'b1 || m_p !== e2 || m_ot !== 8'h33) begin
            n_fail++;
            $display("FAIL stream_2: ov=%b p=%h tag=%h want 1 %h 33",
                     m_ov, m_p, m_ot, e2);
        end
        cyc();
        n_tests++;
        if (m_ov !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_idle: ov=%b want 0", m_ov);
        end
    endtask

    task automatic test_back_pressure();
        logic [31:0] a [5];
        logic [31:0] b [5];
        logic        s [5];
        logic [63:0] e [5];
        int idx;
        int got;
        int budget;
        bit acc;
        for (int i = 0; i < 5; i++) begin
            a[i] = rnd32();
            b[i] = rnd32();
            s[i] = 1'($urandom_range(0, 1));
            e[i] = ref_mul(a[i], b[i], s[i], 32, 32, 64);
        end
        m_or = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_m(a[i], b[i], s[i], 8'(8'h40 + i));
            #1;
            n_tests++;
            if (m_ir !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_accept_%0d: in_ready=%b want 1",
                         i, m_ir);
            end
            cyc();
        end
        drive_m(a[3], b[3], s[3], 8'h43);
        for (int i = 0; i < 2; i++) begin
            #1;
            n_tests++;
            if (m_ir !== 1'b0 || m_ov !== 1'b1 || m_p !== e[0]) begin
                n_fail++;
                $display("FAIL bp_full_%0d: ir=%b ov=%b p=%h want 0 1 %h",
                         i, m_ir, m_ov, m_p, e[0]);
            end
            cyc();
        end
        m_or = 1'b1;
        #1;
        n_tests++;
        if (m_ir !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_simul: in_ready=%b want 1", m_ir);
        end
        idx = 3;
        got = 0;
        budget = 0;
        while (got < 5 && budget < 30) begin
            acc = m_iv && m_ir;
            if (m_ov && m_or) begin
                n_tests++;
                if (m_p !== e[got] || m_ot !== 8'(8'h40 + got)) begin
                    n_fail++;
                    $display("FAIL bp_drain_%0d: p=%h tag=%h want %h %h",
                             got, m_p, m_ot, e[got], 8'(8'h40 + got));
                end
                got++;
            end
            cyc();
            budget++;
            if (acc) idx++;
            if (idx < 5) drive_m(a[idx], b[idx], s[idx], 8'(8'h40 + idx));
            else m_iv = 1'b0;
            #1;
        end
        n_tests++;
        if (got != 5) begin
            n_fail++;
            $display("FAIL bp_timeout: drained %0d want 5", got);
        end
        m_iv = 1'b0;
    endtask

    task automatic test_bubble();
        logic [63:0] ea, eb;
        logic [31:0] a1, b1, a2, b2;
        a1 = rnd32();
        b1 = rnd32();
        a2 = rnd32();
        b2 = rnd32();
        ea = ref_mul(a1, b1, 1'b1, 32, 32, 64);
        eb = ref_mul(a2, b2, 1'b0, 32, 32, 64);
        m_or = 1'b0;
        drive_m(a1, b1, 1'b1, 8'hA1);
        cyc();
        m_iv = 1'b0;
        cyc();
        drive_m(a2, b2, 1'b0, 8'hB2);
        cyc();
        m_iv = 1'b0;
        repeat (3) cyc();
        n_tests++;
        if (m_ov !== 1'b1 || m_p !== ea || m_ot !== 8'hA1 || m_ir !== 1'b1)
        begin
            n_fail++;
            $display("FAIL bubble_hold: ov=%b p=%h tag=%h ir=%b want 1 %h A1 1",
                     m_ov, m_p, m_ot, m_ir, ea);
        end
        m_or = 1'b1;
        cyc();
        n_tests++;
        if (m_ov !== 1'b1 || m_p !== eb || m_ot !== 8'hB2) begin
            n_fail++;
            $display("FAIL bubble_adjacent: ov=%b p=%h tag=%h want 1 %h B2",
                     m_ov, m_p, m_ot, eb);
        end
        cyc();
        n_tests++;
        if (m_ov !== 1'b0) begin
            n_fail++;
            $display("FAIL bubble_empty: ov=%b want 0", m_ov);
        end
    endtask

    task automatic test_width();
        logic [15:0] va [6];
        logic [15:0] vb [6];
        logic        vs [6];
        logic [15:0] eh;
        logic [39:0] ex;
        logic [63:0] r;
        int wait_n;
        va[0] = 16'h8000; vb[0] = 16'h0002; vs[0] = 1'b1;
        va[1] = 16'hFFFE; vb[1] = 16'h0003; vs[1] = 1'b1;
        for (int i = 2; i < 6; i++) begin
            va[i] = 16'($urandom);
            vb[i] = 16'($urandom);
            vs[i] = 1'($urandom_range(0, 1));
        end
        h_or = 1'b1;
        x_or = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin
                eh = 16'h0000;
                ex = 40'hFF_FFFF_0000;
            end else if (i == 1) begin
                eh = 16'hFFFA;
                ex = 40'hFF_FFFF_FFFA;
            end else begin
                r  = ref_mul({16'd0, va[i]}, {16'd0, vb[i]}, vs[i], 16, 16, 16);
                eh = r[15:0];
                r  = ref_mul({16'd0, va[i]}, {16'd0, vb[i]}, vs[i], 16, 16, 40);
                ex = r[39:0];
            end
            h_iv = 1'b1; h_a = va[i]; h_b = vb[i]; h_is = vs[i];
            h_it = 8'(i);
            x_iv = 1'b1; x_a = va[i]; x_b = vb[i]; x_is = vs[i];
            x_it = 8'(i);
            #1;
            n_tests++;
            if (h_ir !== 1'b1 || x_ir !== 1'b1) begin
                n_fail++;
                $display("FAIL width_ready_%0d: ir16=%b ir40=%b want 1",
                         i, h_ir, x_ir);
            end
            cyc();
            h_iv = 1'b0;
            x_iv = 1'b0;
            wait_n = 0;
            while (h_ov !== 1'b1 && wait_n < 10) begin
                cyc();
                wait_n++;
            end
            n_tests++;
            if (h_ov !== 1'b1 || h_p !== eh || h_ot !== 8'(i)) begin
                n_fail++;
                $display("FAIL width16_%0d: ov=%b p=%h want 1 %h",
                         i, h_ov, h_p, eh);
            end
            n_tests++;
            if (x_ov !== 1'b1 || x_p !== ex || x_ot !== 8'(i)) begin
                n_fail++;
                $display("FAIL width40_%0d: ov=%b p=%h want 1 %h",
                         i, x_ov, x_p, ex);
            end
            cyc();
        end
    endtask

    task automatic test_flush_reset();
        int seen;
        int wait_n;
        logic [31:0] a, b;
        logic [63:0] e;
        m_or = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_m(rnd32(), rnd32(), 1'b1, 8'(8'h60 + i));
            cyc();
        end
        drive_m(rnd32(), rnd32(), 1'b0, 8'h6F);
        m_or = 1'b1;
        flush = 1'b1;
        #1;
        n_tests++;
        if (m_ir !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_ready: in_ready=%b want 0", m_ir);
        end
        cyc();
        flush = 1'b0;
        m_iv = 1'b0;
        #1;
        n_tests++;
        if (m_ov !== 1'b0 || m_ir !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_clear: ov=%b ir=%b want 0 1", m_ov, m_ir);
        end
        seen = 0;
        repeat (6) begin
            cyc();
            if (m_ov === 1'b1) seen++;
        end
        n_tests++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL flush_emit: %0d results after flush want 0", seen);
        end
        m_or = 1'b0;
        drive_m(rnd32(), rnd32(), 1'b0, 8'h71);
        cyc();
        drive_m(rnd32(), rnd32(), 1'b1, 8'h72);
        cyc();
        m_iv = 1'b0;
        cyc();
        n_tests++;
        if (m_ov !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre: ov=%b want 1", m_ov);
        end
        aclr_n = 1'b0;
        #1;
        n_tests++;
        if (m_ov !== 1'b0 || m_p !== 64'd0 || m_ot !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_mid: ov=%b p=%h tag=%h want 0/0/0",
                     m_ov, m_p, m_ot);
        end
        repeat (2) cyc();
        aclr_n = 1'b1;
        m_or = 1'b1;
        seen = 0;
        repeat (6) begin
            cyc();
            if (m_ov === 1'b1) seen++;
        end
        n_tests++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL reset_emit: %0d results after reset want 0", seen);
        end
        a = rnd32();
        b = rnd32();
        e = ref_mul(a, b, 1'b1, 32, 32, 64);
        drive_m(a, b, 1'b1, 8'h7E);
        cyc();
        m_iv = 1'b0;
        wait_n = 0;
        while (m_ov !== 1'b1 && wait_n < 10) begin
            cyc();
            wait_n++;
        end
        n_tests++;
        if (m_ov !== 1'b1 || m_p !== e || m_ot !== 8'h7E) begin
            n_fail++;
            $display("FAIL reset_recover: ov=%b p=%h tag=%h want 1 %h 7E",
                     m_ov, m_p, m_ot, e);
        end
        cyc();
    endtask

    task automatic test_single_stage();
        logic [63:0] q_p [$];
        logic [7:0]  q_t [$];
        logic [63:0] pp, ep;
        logic [7:0]  pt, et;
        int  sent, got, cycles;
        bit  pv, pr, hold, acc;
        sent = 0; got = 0; cycles = 0;
        pv = 1'b0; pr = 1'b0; hold = 1'b0;
        pp = '0; pt = '0;
        s_iv = 1'b0;
        while ((sent < 10000 || got < sent) && cycles < 60000) begin
            if (pv && !pr) begin
                n_tests++;
                if (s_ov !== 1'b1 || s_p !== pp || s_ot !== pt) begin
                    n_fail++;
                    $display("FAIL p1_stall: ov=%b p=%h tag=%h want 1 %h %h",
                             s_ov, s_p, s_ot, pp, pt);
                end
            end
            if (!hold) begin
                if (sent < 10000) begin
                    s_iv = ($urandom_range(0, 3) != 0);
                    s_a  = rnd32();
                    s_b  = rnd32();
                    s_is = 1'($urandom_range(0, 1));
                    s_it = 8'($urandom);
                end else begin
                    s_iv = 1'b0;
                end
            end
            s_or = ($urandom_range(0, 2) != 0);
            #1;
            if (s_ov && s_or) begin
                n_tests++;
                if (q_p.size() == 0) begin
                    n_fail++;
                    $display("FAIL p1_extra: p=%h tag=%h want no result",
                             s_p, s_ot);
                end else begin
                    ep = q_p.pop_front();
                    et = q_t.pop_front();
                    got++;
                    if (s_p !== ep || s_ot !== et) begin
                        n_fail++;
                        $display("FAIL p1_result_%0d: p=%h tag=%h want %h %h",
                                 got, s_p, s_ot, ep, et);
                    end
                end
            end
            acc = s_iv && s_ir;
            if (acc) begin
                q_p.push_back(ref_mul(s_a, s_b, s_is, 32, 32, 64));
                q_t.push_back(s_it);
                sent++;
            end
            hold = s_iv && !acc;
            pv = s_ov;
            pr = s_or;
            pp = s_p;
            pt = s_ot;
            cyc();
            cycles++;
        end
        s_iv = 1'b0;
        n_tests++;
        if (sent != 10000 || got != sent) begin
            n_fail++;
            $display("FAIL p1_timeout: sent %0d got %0d want 10000 10000",
                     sent, got);
        end
    endtask

    initial begin
        aclr_n = 1'b0;
        flush  = 1'b0;
        m_iv = 0; m_a = 0; m_b = 0; m_is = 0; m_it = 0; m_or = 0;
        s_iv = 0; s_a = 0; s_b = 0; s_is = 0; s_it = 0; s_or = 0;
        h_iv = 0; h_a = 0; h_b = 0; h_is = 0; h_it = 0; h_or = 0;
        x_iv = 0; x_a = 0; x_b = 0; x_is = 0; x_it = 0; x_or = 0;
        #3;
        test_reset();
        test_stream();
        test_back_pressure();
        test_bubble();
        test_width();
        test_flush_reset();
        test_single_stage();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
